// File: rtl/piso_tx_scheduler.sv
// Two-requester scheduler that feeds one WIDTH-bit PISO: arbitrate, load, shift, gap.
// Define PISO_FIXED_PRIORITY_EN for fixed priority (req0 wins ties); default is round robin.
module piso_tx_scheduler #(
  parameter int WIDTH      = 10,
  parameter int GAP_CYCLES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] piso_data,
  output logic             piso_load_n,
  output logic             tx_active,
  output logic             done,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_t;

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] C_PEN  = CW'((WIDTH > 1) ? WIDTH - 2 : 0);
  localparam logic [GW-1:0] G_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [GW-1:0] gcnt;
  logic          last_grant;
  logic          pick1;

  // last_grant: 0 = requester 0 won last, 1 = requester 1 won last
`ifdef PISO_FIXED_PRIORITY_EN
  assign pick1 = req1 & ~req0;
`else
  assign pick1 = req1 & (~req0 | ~last_grant);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      gcnt        <= '0;
      last_grant  <= 1'b1;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      piso_data   <= '0;
      piso_load_n <= 1'b1;
      tx_active   <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            state       <= LOAD;
            piso_data   <= pick1 ? data1 : data0;
            gnt0        <= ~pick1;
            gnt1        <= pick1;
            last_grant  <= pick1;
            piso_load_n <= 1'b0;
            busy        <= 1'b1;
          end
        end
        LOAD: begin
          state       <= SHIFT;
          piso_load_n <= 1'b1;
          tx_active   <= 1'b1;
          cnt         <= '0;
          done        <= (WIDTH == 1);
        end
        SHIFT: begin
          if (cnt == C_LAST) begin
            tx_active <= 1'b0;
            if (GAP_CYCLES > 0) begin
              state <= GAP;
              gcnt  <= '0;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt  <= cnt + 1'b1;
            done <= (cnt == C_PEN);
          end
        end
        GAP: begin
          if (gcnt == G_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gcnt <= gcnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Bench for piso_tx_scheduler: frame table, contention, mid-frame reset, late request.
// A second instance with GAP_CYCLES=0 runs with both requests held throughout.
module tb_piso_tx_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [9:0] data0, data1;
  logic       gnt0, gnt1, piso_load_n, tx_active, done, busy;
  logic [9:0] piso_data;

  logic       z_req = 1'b1;
  logic [9:0] z_d0 = 10'h155;
  logic [9:0] z_d1 = 10'h2AA;
  logic       z_gnt0, z_gnt1, z_load_n, z_tx, z_done, z_busy;
  logic [9:0] z_pd;

  always #5 clk = ~clk;

  piso_tx_scheduler #(.WIDTH(10), .GAP_CYCLES(2)) u_dut (
    .clk(clk), .reset(reset),
    .req0(req0), .data0(data0), .req1(req1), .data1(data1),
    .gnt0(gnt0), .gnt1(gnt1), .piso_data(piso_data),
    .piso_load_n(piso_load_n), .tx_active(tx_active),
    .done(done), .busy(busy)
  );

  piso_tx_scheduler #(.WIDTH(10), .GAP_CYCLES(0)) u_gap0 (
    .clk(clk), .reset(reset),
    .req0(z_req), .data0(z_d0), .req1(z_req), .data1(z_d1),
    .gnt0(z_gnt0), .gnt1(z_gnt1), .piso_data(z_pd),
    .piso_load_n(z_load_n), .tx_active(z_tx),
    .done(z_done), .busy(z_busy)
  );

  typedef struct packed {
    logic [1:0] who;
    logic [9:0] d;
  } exp_t;

  typedef struct {
    logic       ln, g0, g1, tx, dn, bs;
    logic [9:0] pd;
  } row_t;

  exp_t q[$];
  row_t tbl[1:14];
  int   vec = 0;
  int   bad = 0;
  int   cyc = 0;
  int   z_last = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] ex);
    vec++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, ex, cyc);
    end
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (gnt0 | gnt1) begin
      if (q.size() == 0) begin
        chk("unexpected_grant", {30'b0, gnt1, gnt0}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("grant_who", {30'b0, gnt1, gnt0}, {30'b0, e.who});
        chk("grant_data", {22'b0, piso_data}, {22'b0, e.d});
      end
    end
    if (!reset && !z_load_n) begin
      if (z_last >= 0) chk("gap0_period", cyc - z_last, 32'd12);
      z_last = cyc;
    end
  endtask

  int g, last, dones, t0;

  initial begin
    for (int i = 1; i <= 14; i++) begin
      tbl[i].ln = (i != 1);
      tbl[i].g0 = (i == 1);
      tbl[i].g1 = 1'b0;
      tbl[i].tx = (i >= 2 && i <= 11);
      tbl[i].dn = (i == 11);
      tbl[i].bs = (i <= 13);
      tbl[i].pd = 10'h12F;
    end

    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    data0 = '0; data1 = '0;
    step();
    step();
    chk("rst_outputs", {26'b0, piso_load_n, gnt0, gnt1, tx_active, done, busy},
        {26'b0, 6'b100000});
    chk("rst_piso_data", {22'b0, piso_data}, 32'd0);
    reset = 1'b0;
    step();

    // single frame, with data0 changed mid-shift
    req0 = 1'b1; data0 = 10'b0100101111;
    q.push_back({2'b01, 10'h12F});
    for (int i = 1; i <= 14; i++) begin
      step();
      chk($sformatf("frame_ctl_%0d", i),
          {26'b0, piso_load_n, gnt0, gnt1, tx_active, done, busy},
          {26'b0, tbl[i].ln, tbl[i].g0, tbl[i].g1, tbl[i].tx, tbl[i].dn, tbl[i].bs});
      chk($sformatf("frame_pd_%0d", i), {22'b0, piso_data}, {22'b0, tbl[i].pd});
      if (i == 1) req0 = 1'b0;
      if (i == 5) data0 = 10'h3FF;
    end

    // contention from reset
    reset = 1'b1;
    step();
    reset = 1'b0;
    z_last = -1;
    req0 = 1'b1; req1 = 1'b1; data0 = 10'h155; data1 = 10'h2AA;
`ifdef PISO_FIXED_PRIORITY_EN
    for (int k = 0; k < 4; k++) q.push_back({2'b01, 10'h155});
`else
    for (int k = 0; k < 2; k++) begin
      q.push_back({2'b01, 10'h155});
      q.push_back({2'b10, 10'h2AA});
    end
`endif
    g = 0; last = -1;
    for (int k = 0; k < 80 && g < 4; k++) begin
      step();
      if (gnt0 | gnt1) begin
        if (last >= 0) chk("rr_spacing", cyc - last, 32'd14);
        last = cyc;
        g++;
        if (g == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_grants", g, 32'd4);
    chk("rr_queue_empty", q.size(), 32'd0);
    q.delete();
    for (int k = 0; k < 13; k++) step();

    // mid-frame reset on shift cycle 5
    req1 = 1'b1; data1 = 10'h0F0;
    q.push_back({2'b10, 10'h0F0});
    for (int k = 0; k < 5 && !gnt1; k++) step();
    chk("mr_gnt", {31'b0, gnt1}, 32'd1);
    req1 = 1'b0;
    for (int k = 0; k < 5; k++) step();
    chk("mr_shifting", {31'b0, tx_active}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_outputs", {26'b0, piso_load_n, gnt0, gnt1, tx_active, done, busy},
        {26'b0, 6'b100000});
    chk("mr_piso_data", {22'b0, piso_data}, 32'd0);
    step();
    step();
    reset = 1'b0;
    z_last = -1;
    dones = 0;
    for (int k = 0; k < 15; k++) begin
      step();
      if (done) dones++;
    end
    chk("mr_no_done", dones, 32'd0);
    req0 = 1'b1; req1 = 1'b1; data0 = 10'h155; data1 = 10'h2AA;
    q.push_back({2'b01, 10'h155});
    step();
    chk("mr_restart_load", {29'b0, piso_load_n, gnt0, gnt1}, {29'b0, 3'b010});
    req0 = 1'b0; req1 = 1'b0;
    for (int k = 0; k < 20; k++) step();
    chk("mr_idle_after", {31'b0, busy}, 32'd0);

    // late request raised during GAP
    req0 = 1'b1; data0 = 10'h12F;
    q.push_back({2'b01, 10'h12F});
    step();
    t0 = cyc;
    chk("late_gnt0", {31'b0, gnt0}, 32'd1);
    req0 = 1'b0;
    for (int k = 0; k < 11; k++) step();
    chk("late_in_gap", {30'b0, busy, tx_active}, {30'b0, 2'b10});
    req1 = 1'b1; data1 = 10'h0F0;
    q.push_back({2'b10, 10'h0F0});
    step();
    step();
    chk("late_idle", {30'b0, busy, gnt1}, 32'd0);
    step();
    chk("late_gnt1", {31'b0, gnt1}, 32'd1);
    chk("late_gnt1_cycle", cyc - t0, 32'd14);
    req1 = 1'b0;
    for (int k = 0; k < 14; k++) step();
    chk("final_queue_empty", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx_scheduler.md
Name: piso_tx_scheduler

Overview:
- Two-requester scheduler that shares one 10-bit parallel-in/serial-out shift register between two word sources.
- Arbitrates between the requesters and captures the winner's word onto the PISO parallel input.
- Drives the PISO active-low load strobe for exactly one cycle, then holds it high for WIDTH shift cycles.
- Enforces an idle gap before the next frame; sits directly upstream of the PISO in the serial transmit path.

Parameters:
- WIDTH, 10: word width and number of shift cycles per frame; must match the PISO.
- GAP_CYCLES, 2: idle cycles inserted after each frame (0 allowed).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  requester 0 has a word pending; held until gnt0 is seen.
- data0  input  WIDTH  requester 0 word; stable while req0=1.
- req1  input  1  requester 1 has a word pending; held until gnt1 is seen.
- data1  input  WIDTH  requester 1 word; stable while req1=1.
- gnt0  output  1  one-cycle pulse: requester 0 word accepted.
- gnt1  output  1  one-cycle pulse: requester 1 word accepted.
- piso_data  output  WIDTH  registered word to the PISO parallel input.
- piso_load_n  output  1  active-low load strobe to the PISO.
- tx_active  output  1  high on each cycle the PISO is shifting a valid bit.
- done  output  1  one-cycle pulse on the last shift cycle of a frame.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high. All outputs are registered.
- Reset values: state=IDLE, piso_load_n=1, piso_data=0, gnt0=gnt1=0, tx_active=0, done=0, busy=0, last_grant=1 (requester 0 wins the first tie).
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - req0/req1 are sampled only in IDLE.
  - If any request is high, the winner's data is captured into piso_data and the FSM moves to LOAD.
  - last_grant is updated to the winner.
- Arbitration:
  - Only one request high: that requester wins.
  - Both high: the requester not equal to last_grant wins (round robin).
- LOAD (exactly 1 cycle): piso_load_n=0, winner's gnt=1, busy=1, tx_active=0. Next state SHIFT.
- SHIFT (exactly WIDTH cycles):
  - piso_load_n=1, tx_active=1, piso_data held.
  - Bit counter runs 0..WIDTH-1, width clog2(WIDTH).
  - done=1 only when counter=WIDTH-1.
  - Next state is GAP if GAP_CYCLES>0, else IDLE.
- GAP (GAP_CYCLES cycles): piso_load_n=1, tx_active=0, busy=1. Next state IDLE.
- Frame period: 1 (IDLE) + 1 (LOAD) + WIDTH + GAP_CYCLES cycles; 14 at the defaults.
- Requester handshake:
  - The requester must deassert req on the edge that ends the gnt cycle.
  - req still high in the cycle after gnt counts as a new request.
- Data stability: data changes after capture are ignored; piso_data changes only on the IDLE->LOAD transition.
- Request dropped before grant: no grant, no frame; the FSM stays in IDLE.
- Requests arriving during LOAD/SHIFT/GAP: not lost as long as req is held; serviced on the next IDLE.
- Reset mid-frame: immediate abort to reset values. No done pulse for the aborted frame; last_grant returns to 1.
- No output is X after reset.

Optional Feature:
- Macro: PISO_FIXED_PRIORITY_EN.
- Defined: fixed priority; req0 always wins when both are high. last_grant is still updated but ignored.
- Undefined: round-robin arbitration as described above.

Test Plan:
- Single request: req0=1, data0=10'b0100101111 in IDLE at cycle t.
  - Cycle t+1: piso_data=0x12F, piso_load_n=0, gnt0=1.
  - Cycles t+2..t+11: tx_active=1.
  - Cycle t+11: done=1.
  - Cycles t+12..t+13: GAP, busy=1.
  - Cycle t+14: busy=0.
- Contention after reset: req0 and req1 held high, data0=0x155, data1=0x2AA.
  - Grants alternate gnt0, gnt1, gnt0, gnt1 with 14-cycle spacing; piso_data alternates 0x155/0x2AA.
  - With PISO_FIXED_PRIORITY_EN defined: only gnt0 pulses.
- Mid-frame reset: assert reset on shift cycle 5 of a frame.
  - Outputs immediately return to reset values; no done.
  - The next frame starts cleanly with a LOAD cycle after reset is released.
- Data change after grant: change data0 to 0x3FF during SHIFT → piso_data stays 0x12F until the frame ends.
- Late request: req1 rises in GAP → gnt1 pulses exactly 1 cycle after the FSM returns to IDLE; no frames overlap.
- GAP_CYCLES=0 with both requests held: frame period is WIDTH+2=12 cycles; piso_load_n is low exactly once per frame.
